// File: rtl/kd_mul_reduce.sv
// rtl/kd_mul_reduce.sv - pipelined Kyber/Dilithium modular multiply stage ahead of the butterfly adder
module kd_mul_reduce (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_mode,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        hold,
  input  logic [23:0] data_in,
  input  logic [22:0] omega,
  output logic        out_valid,
  output logic        out_last,
  output logic [23:0] data_out
);

  localparam int unsigned KQ  = 3329;
  localparam int unsigned DQ  = 8380417;
  localparam int unsigned LAT = 4;

  // Barrett multipliers floor(2^k / q), with k equal to the product width of each mode.
  // The Kyber product is below 2^24 and the Dilithium product below 2^46. So the quotient
  // estimate is short by at most one, and the partial remainder lies in [0, 2q).
  localparam logic [63:0] KM = (64'd1 << 24) / 64'(KQ);
  localparam logic [63:0] DM = (64'd1 << 46) / 64'(DQ);

  // S1 registers
  logic        s1_valid;
  logic        s1_last;
  logic        s1_mode;
  logic [11:0] s1_t1;
  logic [22:0] s1_a;
  logic [22:0] s1_w;

  // S2 registers
  logic        s2_valid;
  logic        s2_last;
  logic        s2_mode;
  logic [11:0] s2_t1;
  logic [45:0] s2_prod;

  // S3 registers
  logic        s3_valid;
  logic        s3_last;
  logic        s3_mode;
  logic [11:0] s3_t1;
  logic [24:0] s3_rem;

  // S3 combinational Barrett terms
  logic [36:0] k_qfull;
  logic [12:0] k_qest;
  logic [37:0] k_qq;
  logic [24:0] k_rem;
  logic [69:0] d_qfull;
  logic [23:0] d_qest;
  logic [47:0] d_qq;
  logic [24:0] d_rem;
  logic [24:0] rem_c;

  // S4 combinational correction terms
  logic [24:0] q_sel;
  logic [24:0] r1;
  logic [24:0] r2;
  logic [23:0] result_c;

  logic unused_bits;

  // S1: register the operands; Kyber operands are narrowed to 12 bits here, so the shared
  // multiplier forms a 12x12 product in that mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
      s1_t1    <= '0;
      s1_a     <= '0;
      s1_w     <= '0;
    end else if (!hold) begin
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      s1_mode  <= mul_mode;
      s1_t1    <= data_in[23:12];
      s1_a     <= mul_mode ? data_in[22:0] : {11'd0, data_in[11:0]};
      s1_w     <= mul_mode ? omega : {11'd0, omega[11:0]};
    end
  end

  // S2: shared 23x23 multiply; T1 and mode travel alongside the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_mode  <= 1'b0;
      s2_t1    <= '0;
      s2_prod  <= '0;
    end else if (!hold) begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_mode  <= s1_mode;
      s2_t1    <= s1_t1;
      s2_prod  <= 46'(s1_a) * 46'(s1_w);
    end
  end

  // S3 combinational: the quotient estimate for each modulus, then the low 25 bits of x - q_est*q.
  // The true partial remainder is below 2^25, so wrap-around subtraction in 25 bits is exact.
  always_comb begin
    k_qfull = 37'(s2_prod[23:0]) * 37'(KM);
    k_qest  = k_qfull[36:24];
    k_qq    = 38'(k_qest) * 38'(KQ);
    k_rem   = s2_prod[24:0] - k_qq[24:0];
    d_qfull = 70'(s2_prod) * 70'(DM);
    d_qest  = d_qfull[69:46];
    d_qq    = 48'(d_qest) * 48'(DQ);
    d_rem   = s2_prod[24:0] - d_qq[24:0];
    rem_c   = s2_mode ? d_rem : k_rem;
  end

  // S3: register the partial remainder selected by the element's own mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_mode  <= 1'b0;
      s3_t1    <= '0;
      s3_rem   <= '0;
    end else if (!hold) begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      s3_mode  <= s2_mode;
      s3_t1    <= s2_t1;
      s3_rem   <= rem_c;
    end
  end

  // S4 combinational: up to two conditional subtractions of q bring the result into [0, q-1].
  // In Kyber mode the result is repacked with the untouched T1.
  always_comb begin
    q_sel    = s3_mode ? 25'(DQ) : 25'(KQ);
    r1       = (s3_rem >= q_sel) ? (s3_rem - q_sel) : s3_rem;
    r2       = (r1 >= q_sel) ? (r1 - q_sel) : r1;
    result_c = s3_mode ? {1'b0, r2[22:0]} : {s3_t1, r2[11:0]};
  end

  // S4: output register; out_last is qualified by valid, so it never appears on a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      data_out  <= '0;
    end else if (!hold) begin
      out_valid <= s3_valid;
      out_last  <= s3_valid & s3_last;
      data_out  <= result_c;
    end
  end

  assign unused_bits = &{1'b0, data_in[23], k_qfull[23:0], k_qq[37:25], d_qfull[45:0],
                         d_qq[47:25], r2[24:23], 32'(LAT)};

endmodule

// File: tb/tb_kd_mul_reduce.sv
// tb/tb_kd_mul_reduce.sv - directed self-checking bench for kd_mul_reduce
module tb_kd_mul_reduce;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_mode;
  logic        in_valid;
  logic        in_last;
  logic        hold;
  logic [23:0] data_in;
  logic [22:0] omega;
  logic        out_valid;
  logic        out_last;
  logic [23:0] data_out;

  int n_vec  = 0;
  int n_miss = 0;

  localparam int N = 9;
  logic        v_mode [N];
  logic [23:0] v_data [N];
  logic [22:0] v_omega[N];
  logic [23:0] v_exp  [N];

  always #5 clk = ~clk;

  kd_mul_reduce dut (
    .clk       (clk),
    .rst       (rst),
    .mul_mode  (mul_mode),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .hold      (hold),
    .data_in   (data_in),
    .omega     (omega),
    .out_valid (out_valid),
    .out_last  (out_last),
    .data_out  (data_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mul_mode = 1'b0;
    data_in  = '0;
    omega    = '0;
  endtask

  task automatic drive(input int i, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    mul_mode = v_mode[i];
    data_in  = v_data[i];
    omega    = v_omega[i];
  endtask

  initial begin
    // Stream of alternating Kyber (0) and Dilithium (1) vectors with hand-computed results
    v_mode[0] = 1'b0; v_data[0] = 24'h064D00; v_omega[0] = 23'd17;       v_exp[0] = 24'h064CF0;
    v_mode[1] = 1'b1; v_data[1] = 24'h7FE000; v_omega[1] = 23'h7FE000;   v_exp[1] = 24'h000001;
    v_mode[2] = 1'b0; v_data[2] = 24'hFFFFFF; v_omega[2] = 23'd4095;     v_exp[2] = 24'hFFF354;
    v_mode[3] = 1'b1; v_data[3] = 24'h7FFFFF; v_omega[3] = 23'd2;        v_exp[3] = 24'h003FFC;
    v_mode[4] = 1'b0; v_data[4] = 24'hABC001; v_omega[4] = 23'd1;        v_exp[4] = 24'hABC001;
    v_mode[5] = 1'b1; v_data[5] = 24'h800000; v_omega[5] = 23'd5;        v_exp[5] = 24'h000000;
    v_mode[6] = 1'b0; v_data[6] = 24'h000D00; v_omega[6] = 23'h7FF011;   v_exp[6] = 24'h000CF0;
    v_mode[7] = 1'b1; v_data[7] = 24'h000001; v_omega[7] = 23'h7FFFFF;   v_exp[7] = 24'h001FFE;
    v_mode[8] = 1'b0; v_data[8] = 24'h123D01; v_omega[8] = 23'd3329;     v_exp[8] = 24'h123000;

    rst  = 1'b1;
    hold = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset data_out", 32'(data_out), 32'd0);

    // Single Kyber element: valid exactly after the 4th edge
    drive(0, 1'b1);
    for (int t = 1; t <= 6; t++) begin
      tick();
      idle();
      chk($sformatf("lat valid t%0d", t), 32'(out_valid), 32'(t == 4));
      if (t == 4) begin
        chk("lat data", 32'(data_out), 32'(v_exp[0]));
        chk("lat last", 32'(out_last), 32'd1);
      end
    end

    // Back-to-back mixed-mode stream, one result per cycle, last on the final element
    for (int c = 0; c < N + 4; c++) begin
      if (c < N) drive(c, c == N - 1);
      else idle();
      tick();
      if (c >= 3 && c - 3 < N) begin
        chk($sformatf("stream valid %0d", c - 3), 32'(out_valid), 32'd1);
        chk($sformatf("stream data %0d", c - 3), 32'(data_out), 32'(v_exp[c - 3]));
        chk($sformatf("stream last %0d", c - 3), 32'(out_last), 32'(c - 3 == N - 1));
      end else begin
        chk($sformatf("stream bubble c%0d", c), 32'(out_valid), 32'd0);
      end
    end

    // Hold: A (Kyber) and B (Dilithium) in flight; hold on ticks 4-6 and 8-9.
    // Junk is presented with in_valid=1 during hold and must be ignored.
    for (int t = 1; t <= 12; t++) begin
      logic h;
      h = (t >= 4 && t <= 6) || t == 8 || t == 9;
      hold = h;
      if (t == 1) drive(0, 1'b0);
      else if (t == 2) drive(1, 1'b1);
      else if (h) begin
        in_valid = 1'b1;
        in_last  = 1'b1;
        mul_mode = 1'b1;
        data_in  = 24'h123456;
        omega    = 23'd3;
      end else idle();
      tick();
      if (t >= 7 && t <= 9) begin
        chk($sformatf("hold A valid t%0d", t), 32'(out_valid), 32'd1);
        chk($sformatf("hold A data t%0d", t), 32'(data_out), 32'(v_exp[0]));
        chk($sformatf("hold A last t%0d", t), 32'(out_last), 32'd0);
      end else if (t == 10) begin
        chk("hold B valid", 32'(out_valid), 32'd1);
        chk("hold B data", 32'(data_out), 32'(v_exp[1]));
        chk("hold B last", 32'(out_last), 32'd1);
      end else begin
        chk($sformatf("hold bubble t%0d", t), 32'(out_valid), 32'd0);
      end
    end
    hold = 1'b0;
    idle();

    // Reset with three elements in flight: everything is discarded
    for (int i = 0; i < 3; i++) begin
      drive(i + 1, 1'b1);
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst flight valid", 32'(out_valid), 32'd0);
    chk("rst flight data", 32'(data_out), 32'd0);
    chk("rst flight last", 32'(out_last), 32'd0);
    for (int t = 0; t < 8; t++) begin
      tick();
      chk($sformatf("post rst quiet t%0d", t), 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/kd_mul_reduce.md
Name: kd_mul_reduce

Overview:
- Pipelined modular multiply stage directly upstream of the dual-mode add/sub butterfly adder.
- Kyber mode (q=3329): input is {T1,T3}. The stage computes T3·ω mod q and re-packs it with T1, delay-matched, as {T1, T3·ω mod q}. That packed word is what the adder consumes.
- Dilithium mode (q=8380417): input is one coefficient B. The stage outputs B·ω mod q zero-extended to 24 bits. The adder passes this through unchanged.

Parameters:
- KQ, 3329, Kyber modulus.
- DQ, 8380417, Dilithium modulus.
- LAT, 4, fixed input-to-output latency in enabled cycles. Not user-overridable; documentation only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mul_mode  input  1  0 = Kyber, 1 = Dilithium; sampled per element with in_valid.
- in_valid  input  1  data_in/omega/mul_mode/in_last valid this cycle.
- in_last  input  1  marks final element of a transform pass.
- hold  input  1  pipeline freeze (downstream back-pressure).
- data_in  input  24  Kyber: {T1[23:12], T3[11:0]}; Dilithium: B in [22:0], bit 23 ignored.
- omega  input  23  twiddle. Kyber uses [11:0], upper bits ignored; Dilithium uses [22:0].
- out_valid  output  1  data_out valid.
- out_last  output  1  in_last delayed with its element.
- data_out  output  24  Kyber: {T1, T3·ω mod KQ}; Dilithium: {1'b0, B·ω mod DQ}.

Behaviour:
Clock and reset:
- One clock.
- Reset is synchronous and active-high on rst, sampled at the clk rising edge.
- Reset clears every stage valid bit, out_valid, out_last and data_out to 0.
- Reset mid-operation discards all in-flight elements; nothing is emitted afterwards.
- rst has priority over hold.

Pipeline stages (each advances only when hold=0):
- S1: register data_in, omega, mul_mode, in_last and in_valid.
- S2: 23x23 multiply, giving a 46-bit product. Kyber uses only 12x12 (24-bit product). T1 and mode travel alongside.
- S3: Barrett quotient estimate for the element's mode, plus partial remainder.
- S4 (output register): final conditional correction subtracts of q (up to two), then output.

Latency:
- An element accepted at edge k appears on data_out/out_valid after edge k+4, provided hold=0 for the whole interval.
- Each hold=1 cycle adds exactly one cycle of delay.

Hold:
- hold=1 freezes all stage registers and outputs, including out_valid/data_out, which remain stable.
- in_valid is ignored while hold=1; upstream must keep presenting the element.
- hold deasserting with out_valid=1 does not duplicate the output. The next edge advances the pipeline normally.

Mode handling:
- Mode is carried per element. Back-to-back elements of different modes are legal with no bubble, and each is reduced by its own modulus.

Arithmetic:
- Result must equal (operand·ω) mod q exactly for every value of the declared operand widths. This includes non-reduced inputs: Kyber T3, ω in [0,4095]; Dilithium B, ω in [0,2^23-1].
- Output is always in [0,q-1].
- T1 is never reduced; it is passed through bit-exact.

Bubbles:
- in_valid=0 produces a bubble. out_valid is 0 for that slot.
- data_out during a bubble is don't-care but must not be X.
- out_last is only asserted together with out_valid.

Test Plan:
- Kyber, data_in=24'h064D00 (T1=100, T3=3328), omega=17 -> after 4 cycles out_valid=1, data_out=24'h064CF0 (3312).
- Kyber unreduced, data_in=24'hFFFFFF, omega=4095 -> data_out=24'hFFF354 (852).
- Dilithium, data_in=8380416, omega=8380416 -> data_out=24'h000001. Then data_in=24'h7FFFFF, omega=2 -> 24'h003FFC (16380).
- Alternating Kyber/Dilithium stream of the above vectors every cycle -> outputs in order, each with correct modulus, 1 result/cycle. out_last tracks the flagged element.
- hold=1 for 3 cycles while two elements are in flight -> out_valid/data_out frozen during hold, latency becomes 7, no loss or duplication.
- rst asserted with 3 elements in flight -> next cycle out_valid=0, data_out=0; with no new input, no further output ever appears.
